switch_frame_reader: RTL and testbench
======================================

SWITCH_FRAME_READER -- requirements
Module: switch_frame_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, FIFO word and output data width.
REQ-002 SHALL have parameter MAX_LEN, default 64, largest legal payload length in words.
REQ-003 SHALL have parameter MAX_RETRY, default 3, replay attempts per frame before giving up.
REQ-004 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-005 SHALL have ports: fifo_rd_data input DATA_WIDTH FIFO head word; fifo_rd_valid input 1 head word valid; fifo_rd_enable output 1 pop.
REQ-006 SHALL have ports: fifo_rd_sof output 1 frame start marker; fifo_rd_eof output 1 frame end marker; fifo_rd_drop output 1 rewind request.
REQ-007 SHALL have ports: out_data output DATA_WIDTH payload; out_valid output 1; out_ready input 1; out_first output 1; out_last output 1; out_abort input 1 downstream rejects current frame.
REQ-008 SHALL have ports: frame_count output 16 good frames delivered; len_error output 1 pulse; retry_exhausted output 1 pulse.

Function
REQ-009 Frame format in FIFO SHALL be one header word (payload length L, unsigned, low bits) followed by L payload words.
REQ-010 A FIFO word SHALL be popped only in a cycle with fifo_rd_valid=1 and fifo_rd_enable=1; fifo_rd_enable SHALL never assert while fifo_rd_valid=0.
REQ-011 States SHALL be IDLE, PAYLOAD, FLUSH, DISCARD.
REQ-012 IDLE: when fifo_rd_valid=1, SHALL pop header with fifo_rd_sof=1 that cycle and latch L and a down-counter.
REQ-013 IDLE header with L=0: SHALL pulse len_error one cycle, remain IDLE.
REQ-014 IDLE header with L>MAX_LEN: SHALL pulse len_error, go to DISCARD; DISCARD pops L words with out_valid=0, asserting fifo_rd_eof on the last pop, then IDLE.
REQ-015 IDLE legal header: SHALL go to PAYLOAD.
REQ-016 PAYLOAD pop condition SHALL be fifo_rd_valid && (!out_valid || out_ready); popped word loaded into output register, out_valid=1 next cycle (latency one cycle pop-to-output).
REQ-017 out_data/out_first/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 out_first SHALL be 1 on the first payload word, out_last on word L; both 1 when L=1.
REQ-019 fifo_rd_eof SHALL assert with the pop of payload word L; state then returns to IDLE (header of next frame may pop the following cycle).
REQ-020 out_abort=1 in PAYLOAD SHALL set a sticky abort flag; from the next cycle out_valid SHALL be 0, output register cleared, state FLUSH.
REQ-021 out_abort on the same cycle as the out_last handshake SHALL be ignored (frame already delivered).
REQ-022 FLUSH SHALL pop remaining words with out_valid=0; last pop SHALL assert fifo_rd_eof, and fifo_rd_drop=1 if retry counter<MAX_RETRY (counter increments, FIFO replays the frame from its header).
REQ-023 If retry counter=MAX_RETRY at the last FLUSH pop, fifo_rd_drop SHALL be 0, retry_exhausted SHALL pulse, counter cleared.
REQ-024 Retry counter SHALL clear on each good frame; width $clog2(MAX_RETRY+1).
REQ-025 frame_count SHALL increment on each out_last handshake (out_valid && out_ready && out_last), wrapping modulo 2^16.
REQ-026 fifo_rd_sof, fifo_rd_eof, fifo_rd_drop SHALL be 0 in any cycle fifo_rd_enable=0.

Reset
REQ-027 rst SHALL force IDLE, out_valid=0, out_data=0, out_first=0, out_last=0, fifo_rd_enable=0, frame_count=0, retry counter=0, abort flag=0, len_error=0, retry_exhausted=0.
REQ-028 rst mid-frame SHALL abandon the frame without asserting fifo_rd_drop; FIFO realignment is the FIFO's reset responsibility.

Structure
REQ-029 State encoding localparams and the header-length field width SHALL live in the shared switch package.
REQ-030 Block SHALL be a single module with an inline output register; no sub-modules.

Verification
REQ-031 Header 3, payload A,B,C, out_ready=1 -> out A(first),B,C(last) on consecutive cycles, fifo_rd_eof with C pop, frame_count=1.
REQ-032 Same frame, out_ready toggling 1,0,1,0 -> no word lost/duplicated, data stable while stalled, pops only when register free.
REQ-033 Header 0, then header 1 with D -> len_error one pulse, then D with out_first=out_last=1.
REQ-034 Header 70 (MAX_LEN=64) -> len_error, 70 pops with out_valid=0, fifo_rd_eof on 70th, next frame delivered normally.
REQ-035 Header 4, out_abort on word 2 -> out_valid drops, words 3-4 flushed, fifo_rd_drop with eof; replay delivered intact, frame_count=1.
REQ-036 Abort on every attempt, MAX_RETRY=3 -> three drops, fourth flush without drop, retry_exhausted pulse, frame_count unchanged.

Source files
------------

// File: rtl/switch_frame_reader_pkg.sv
// Shared definitions for the switch frame reader.
// Holds the FSM state encoding and the width of the header length field
// (the payload length sits in the low HDR_LEN_W bits of the header word).
package switch_frame_reader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PAYLOAD = 2'd1;
    localparam state_t ST_FLUSH   = 2'd2;
    localparam state_t ST_DISCARD = 2'd3;

    // Header length field width; MAX_LEN and DATA_WIDTH must both accommodate it.
    localparam int HDR_LEN_W = 8;

endpackage

// File: rtl/switch_frame_reader.sv
// Purpose: pops length-prefixed frames from a FIFO, delivers payload on a valid/ready stream,
//          rewinds the FIFO on downstream abort (bounded retries), discards zero/oversized frames.
// Latency: one cycle from FIFO pop to out_valid; header pop adds one cycle per frame.
// Backpressure: payload pops only when the output register is empty or being drained (out_ready).
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   fifo_rd_data/valid/enable         FIFO head word, head valid, pop strobe
//   fifo_rd_sof/eof/drop              header pop, last-word pop, rewind-to-header request
//   out_data/valid/ready/first/last   payload stream; out_abort rejects the frame being shown
//   frame_count                       good frames delivered (wraps at 2^16)
//   len_error, retry_exhausted        one-cycle status pulses
module switch_frame_reader
    import switch_frame_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int MAX_LEN    = 64,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_valid,
    output logic                  fifo_rd_enable,
    output logic                  fifo_rd_sof,
    output logic                  fifo_rd_eof,
    output logic                  fifo_rd_drop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    input  logic                  out_abort,
    output logic [15:0]           frame_count,
    output logic                  len_error,
    output logic                  retry_exhausted
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [HDR_LEN_W-1:0] CNT_ONE = HDR_LEN_W'(1);

    state_t                 state_q, state_d;
    logic [HDR_LEN_W-1:0]   len_q;
    logic [HDR_LEN_W-1:0]   cnt_q;      // payload words still to pop
    logic [RW-1:0]          retry_q;
    logic                   abort_q;    // set while flushing an aborted attempt
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   out_valid_q, out_first_q, out_last_q;
    logic [15:0]            frame_count_q;
    logic                   len_error_q, retry_exh_q;

    logic [HDR_LEN_W-1:0]   hdr_len;
    logic                   hdr_zero, hdr_big;
    logic                   out_free, last_hs, abort_take, cnt_last, retry_left;
    logic                   pop, sof, eof, drop;

    assign hdr_len    = fifo_rd_data[HDR_LEN_W-1:0];
    assign hdr_zero   = (hdr_len == '0);
    assign hdr_big    = (int'(hdr_len) > MAX_LEN);
    assign out_free   = !out_valid_q || out_ready;
    assign last_hs    = out_valid_q && out_ready && out_last_q;
    assign cnt_last   = (cnt_q == CNT_ONE);
    assign retry_left = (retry_q < RW'(MAX_RETRY));

    // An abort only applies to the frame currently being shown. While the register
    // still holds the previous frame's last word (stalled or handshaking), that frame
    // is already complete, so the abort is ignored.
    assign abort_take = (state_q == ST_PAYLOAD) && out_abort && !(out_valid_q && out_last_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_rd_valid && !hdr_zero) begin
                    state_d = hdr_big ? ST_DISCARD : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (abort_take) begin
                    state_d = ST_FLUSH;
                end else if (eof) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH, ST_DISCARD: begin
                if (eof) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO-side outputs; every marker is qualified by the pop itself.
    always_comb begin
        pop  = 1'b0;
        sof  = 1'b0;
        eof  = 1'b0;
        drop = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    pop = fifo_rd_valid;
                    sof = fifo_rd_valid;
                end
                ST_PAYLOAD: begin
                    // No pop in the abort cycle; the flush pops the remainder.
                    pop = fifo_rd_valid && out_free && !abort_take;
                    eof = pop && cnt_last;
                end
                ST_FLUSH: begin
                    pop  = fifo_rd_valid;
                    eof  = pop && cnt_last;
                    drop = eof && abort_q && retry_left;
                end
                ST_DISCARD: begin
                    pop = fifo_rd_valid;
                    eof = pop && cnt_last;
                end
                default: ;
            endcase
        end
    end

    // Datapath, output register and status
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q         <= '0;
            cnt_q         <= '0;
            retry_q       <= '0;
            abort_q       <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_first_q   <= 1'b0;
            out_last_q    <= 1'b0;
            frame_count_q <= '0;
            len_error_q   <= 1'b0;
            retry_exh_q   <= 1'b0;
        end else begin
            len_error_q <= 1'b0;
            retry_exh_q <= 1'b0;

            if (state_q == ST_IDLE && pop) begin
                len_q       <= hdr_len;
                cnt_q       <= hdr_len;
                len_error_q <= hdr_zero || hdr_big;
            end else if (pop) begin
                cnt_q <= cnt_q - CNT_ONE;
            end

            if (abort_take) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_first_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if (state_q == ST_PAYLOAD && pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= fifo_rd_data;
                out_first_q <= (cnt_q == len_q);
                out_last_q  <= cnt_last;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (last_hs) begin
                frame_count_q <= frame_count_q + 16'd1;
            end

            if (abort_take) begin
                abort_q <= 1'b1;
            end else if (state_q == ST_FLUSH && eof) begin
                abort_q <= 1'b0;
            end

            // Flush end and a good-frame handshake never coincide: the register is
            // empty for the whole flush.
            if (state_q == ST_FLUSH && eof) begin
                if (retry_left) begin
                    retry_q <= retry_q + RW'(1);
                end else begin
                    retry_q     <= '0;
                    retry_exh_q <= 1'b1;
                end
            end else if (last_hs) begin
                retry_q <= '0;
            end
        end
    end

    assign fifo_rd_enable  = pop;
    assign fifo_rd_sof     = sof;
    assign fifo_rd_eof     = eof;
    assign fifo_rd_drop    = drop;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign out_first       = out_first_q;
    assign out_last        = out_last_q;
    assign frame_count     = frame_count_q;
    assign len_error       = len_error_q;
    assign retry_exhausted = retry_exh_q;

endmodule

// File: tb/tb_switch_frame_reader.sv
// Bench for switch_frame_reader: FIFO model with header rewind, frame-level
// scoreboard of expected payload, pulses and counters, directed frames plus random traffic.
module tb_switch_frame_reader;
    import switch_frame_reader_pkg::*;

    localparam int DW        = 12;
    localparam int MAX_LEN   = 64;
    localparam int MAX_RETRY = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_valid = 1'b0;
    logic          fifo_rd_enable, fifo_rd_sof, fifo_rd_eof, fifo_rd_drop;
    logic [DW-1:0] out_data;
    logic          out_valid, out_first, out_last;
    logic          out_ready = 1'b0;
    logic          out_abort = 1'b0;
    logic [15:0]   frame_count;
    logic          len_error, retry_exhausted;

    switch_frame_reader #(.DATA_WIDTH(DW), .MAX_LEN(MAX_LEN), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_valid(fifo_rd_valid), .fifo_rd_enable(fifo_rd_enable),
        .fifo_rd_sof(fifo_rd_sof), .fifo_rd_eof(fifo_rd_eof), .fifo_rd_drop(fifo_rd_drop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .out_abort(out_abort),
        .frame_count(frame_count), .len_error(len_error), .retry_exhausted(retry_exhausted)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO contents and frame table
    logic [DW-1:0] mem[$];
    bit            is_hdr[$];
    bit            is_eof[$];
    int            frame_of[$];
    int            frm_len[$], frm_base[$], frm_abort_n[$], frm_abort_at[$];
    int            rd_ptr = 0;

    // Scoreboard state
    bit          model_en = 1'b0;
    int          out_frame = 0, out_idx = 0, att = 0, m_retry = 0;
    logic [15:0] m_count = '0;
    bit          flushing = 1'b0, le_exp = 1'b0, ex_exp = 1'b0;
    bit          abort_prev = 1'b0, stall_prev = 1'b0;
    logic [DW-1:0] prev_dat;
    logic        prev_first, prev_last;
    int          n_eof = 0, n_drop = 0, n_le = 0, n_exh = 0, n_hs = 0, ncyc = 0, cyc = 0;
    logic [DW-1:0] hs_dat[8];
    int          hs_cyc[8];
    logic [1:0]  hs_fl[8];

    function automatic bit legal(input int l);
        return (l >= 1) && (l <= MAX_LEN);
    endfunction

    task automatic push_hdr(input int len, input int an, input int aat);
        logic [DW-1:0] h;
        h = DW'($urandom);
        h[HDR_LEN_W-1:0] = len[HDR_LEN_W-1:0];
        frm_len.push_back(len);
        frm_base.push_back(mem.size());
        frm_abort_n.push_back(an);
        frm_abort_at.push_back(aat);
        mem.push_back(h);
        is_hdr.push_back(1'b1);
        is_eof.push_back(1'b0);
        frame_of.push_back(frm_len.size() - 1);
    endtask

    task automatic push_pay(input logic [DW-1:0] w, input bit last);
        mem.push_back(w);
        is_hdr.push_back(1'b0);
        is_eof.push_back(last);
        frame_of.push_back(frm_len.size() - 1);
    endtask

    task automatic push_frame(input int len, input int an, input int aat);
        push_hdr(len, an, aat);
        for (int i = 0; i < len; i++) push_pay(DW'($urandom), i == len - 1);
    endtask

    // Compare process: everything the DUT does is checked against the frame-level model.
    always @(negedge clk) begin
        int  idx, f;
        bit  exp_drop, hs;
        ncyc++;
        if (model_en) begin
            while (out_frame < frm_len.size() && !legal(frm_len[out_frame])) out_frame++;
            chk("len_error", 32'(len_error), 32'(le_exp));
            chk("retry_exhausted", 32'(retry_exhausted), 32'(ex_exp));
            chk("frame_count", 32'(frame_count), 32'(m_count));
            le_exp = 1'b0;
            ex_exp = 1'b0;
            if (len_error) n_le++;
            if (retry_exhausted) n_exh++;
            if (abort_prev) begin
                chk("abort_clears_valid", 32'(out_valid), 32'd0);
            end else if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_dat));
                chk("stall_first", 32'(out_first), 32'(prev_first));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (fifo_rd_enable) begin
                chk("pop_needs_valid", 32'(fifo_rd_valid), 32'd1);
                idx = rd_ptr;
                chk("pop_overrun", 32'(idx < mem.size()), 32'd1);
                if (idx < mem.size()) begin
                    f = frame_of[idx];
                    chk("sof", 32'(fifo_rd_sof), 32'(is_hdr[idx]));
                    chk("eof", 32'(fifo_rd_eof), 32'(is_eof[idx]));
                    if (fifo_rd_eof) n_eof++;
                    if (fifo_rd_drop) n_drop++;
                    if (is_hdr[idx] && !legal(frm_len[f])) le_exp = 1'b1;
                    if (!is_hdr[idx] && legal(frm_len[f]) && !flushing)
                        chk("pop_reg_free", 32'(!out_valid || out_ready), 32'd1);
                    exp_drop = 1'b0;
                    if (is_eof[idx] && flushing) begin
                        exp_drop = (m_retry < MAX_RETRY);
                        if (exp_drop) begin
                            m_retry++;
                        end else begin
                            ex_exp = 1'b1;
                            m_retry = 0;
                            out_frame++;
                            att = 0;
                        end
                        flushing = 1'b0;
                        out_idx = 0;
                    end
                    chk("drop", 32'(fifo_rd_drop), 32'(exp_drop));
                    rd_ptr = fifo_rd_drop ? frm_base[f] : idx + 1;
                end
            end else begin
                chk("flags_without_pop", 32'({fifo_rd_sof, fifo_rd_eof, fifo_rd_drop}), 32'd0);
            end
            hs = out_valid && out_ready;
            if (hs) begin
                if (flushing || out_frame >= frm_len.size()) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    f = out_frame;
                    chk("out_data", 32'(out_data), 32'(mem[frm_base[f] + 1 + out_idx]));
                    chk("out_first", 32'(out_first), 32'(out_idx == 0));
                    chk("out_last", 32'(out_last), 32'(out_idx == frm_len[f] - 1));
                    if (n_hs < 8) begin
                        hs_dat[n_hs] = out_data;
                        hs_cyc[n_hs] = ncyc;
                        hs_fl[n_hs]  = {out_first, out_last};
                    end
                    n_hs++;
                    out_idx++;
                    if (out_idx == frm_len[f]) begin
                        m_count = m_count + 16'd1;
                        m_retry = 0;
                        out_frame++;
                        att = 0;
                        out_idx = 0;
                    end
                end
            end
            if (out_abort) begin
                flushing = 1'b1;
                out_idx = 0;
                att++;
            end
            abort_prev = out_abort;
            stall_prev = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_first = out_first;
            prev_last  = out_last;
        end
    end

    // mode 0: always ready, 1: ready toggles, 2: random ready and FIFO gaps
    task automatic step(input int mode);
        bit vld, ab;
        @(posedge clk);
        #1;
        cyc++;
        vld = (rd_ptr < mem.size());
        if (mode == 2 && $urandom_range(0, 4) == 0) vld = 1'b0;
        fifo_rd_valid = vld;
        if (vld) fifo_rd_data = mem[rd_ptr];
        else     fifo_rd_data = DW'($urandom);
        ab = 1'b0;
        if (out_valid && !out_last && !flushing && out_frame < frm_len.size())
            ab = (att < frm_abort_n[out_frame]) && (out_idx == frm_abort_at[out_frame]);
        out_abort = ab;
        if (ab)             out_ready = 1'b0;
        else if (mode == 0) out_ready = 1'b1;
        else if (mode == 1) out_ready = (cyc % 2) == 1;
        else                out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic run_until_done(input int mode, input int budget);
        int n, quiet;
        n = 0;
        quiet = 0;
        while (quiet < 4 && n < budget) begin
            step(mode);
            n++;
            if (rd_ptr == mem.size() && !out_valid && !flushing && out_frame >= frm_len.size())
                quiet++;
            else
                quiet = 0;
        end
        chk("drain_within_budget", 32'(quiet >= 4), 32'd1);
    endtask

    initial begin
        int len, an, aat, n;
        // Reset with the FIFO claiming valid: nothing may pop.
        rst = 1'b1;
        fifo_rd_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_enable", 32'(fifo_rd_enable), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_first_last", 32'({out_first, out_last}), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_pulses", 32'({len_error, retry_exhausted}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_rd_valid = 1'b0;
        model_en = 1'b1;

        // Directed frames
        push_hdr(3, 0, 0);
        push_pay(12'hA01, 1'b0); push_pay(12'hB02, 1'b0); push_pay(12'hC03, 1'b1);
        push_hdr(0, 0, 0);
        push_hdr(1, 0, 0);
        push_pay(12'hD04, 1'b1);
        push_frame(70, 0, 0);
        push_frame(4, 1, 1);   // abort while word 2 is shown, replay succeeds
        push_frame(2, 4, 0);   // aborted every attempt until retries run out
        push_frame(2, 0, 0);
        run_until_done(0, 2000);

        chk("pin_hs0_data", 32'(hs_dat[0]), 32'h0A01);
        chk("pin_hs1_data", 32'(hs_dat[1]), 32'h0B02);
        chk("pin_hs2_data", 32'(hs_dat[2]), 32'h0C03);
        chk("pin_hs0_fl", 32'(hs_fl[0]), 32'd2);
        chk("pin_hs2_fl", 32'(hs_fl[2]), 32'd1);
        chk("pin_back_to_back_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
        chk("pin_back_to_back_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd1);
        chk("pin_single_data", 32'(hs_dat[3]), 32'h0D04);
        chk("pin_single_fl", 32'(hs_fl[3]), 32'd3);
        chk("pin_frame_count", 32'(frame_count), 32'd4);
        chk("pin_len_errors", 32'(n_le), 32'd2);
        chk("pin_eofs", 32'(n_eof), 32'd10);
        chk("pin_drops", 32'(n_drop), 32'd4);
        chk("pin_exhausted", 32'(n_exh), 32'd1);

        // Toggling ready on the same 3-word frame
        push_hdr(3, 0, 0);
        push_pay(12'hA01, 1'b0); push_pay(12'hB02, 1'b0); push_pay(12'hC03, 1'b1);
        run_until_done(1, 500);
        chk("pin_toggle_count", 32'(frame_count), 32'd5);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 19);
            if (n == 0)      len = 0;
            else if (n == 1) len = $urandom_range(MAX_LEN + 1, 70);
            else             len = $urandom_range(1, 10);
            an = 0;
            aat = 0;
            if (legal(len) && len >= 2) begin
                n = $urandom_range(0, 19);
                if (n < 4)       an = $urandom_range(1, 2);
                else if (n == 4) an = MAX_RETRY + 1;
                aat = $urandom_range(0, len - 2);
            end
            push_frame(len, an, aat);
        end
        run_until_done(2, 20000);

        // Reset in the middle of a frame
        push_frame(8, 0, 0);
        n = 0;
        while (out_idx < 3 && n < 200) begin
            step(0);
            n++;
        end
        chk("reach_mid_frame", 32'(out_idx >= 3), 32'd1);
        model_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_enable", 32'(fifo_rd_enable), 32'd0);
        chk("midrst_flags", 32'({fifo_rd_sof, fifo_rd_eof, fifo_rd_drop}), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_regs", 32'({out_data, out_first, out_last}), 32'd0);
        chk("midrst_frame_count", 32'(frame_count), 32'd0);
        chk("midrst_drop", 32'(fifo_rd_drop), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_rd_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("postrst_idle", 32'({out_valid, fifo_rd_enable, len_error, retry_exhausted}), 32'd0);
        chk("postrst_frame_count", 32'(frame_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
